route_table_responder: RTL and testbench

- Responder end of the router's routing-table lookup interface. The router presents a destination address; this block answers with the output channel index.
- Replaces the fixed combinational table with a registered, run-time programmable table.
- Self-initialises to the standard default map after reset.
- Sits beside each router instance and has a config write port for reprogramming the table.

---
 rtl/route_table_responder_if.sv | 26 ++
 rtl/route_table_responder.sv | 109 ++++++++++
 tb/tb_route_table_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/route_table_responder_if.sv
// Lookup and table-configuration bus between a router and its routing-table responder.
// The master side is the router; the slave side is the responder.
interface route_table_responder_if #(
  parameter int DESTINATION_BITS = 7,
  parameter int CHANNEL_BITS     = 8
);
  logic                        lookup_req;
  logic [DESTINATION_BITS-1:0] lookup_addr;
  logic                        lookup_ack;
  logic [CHANNEL_BITS-1:0]     lookup_data;
  logic                        cfg_we;
  logic [DESTINATION_BITS-1:0] cfg_addr;
  logic [CHANNEL_BITS-1:0]     cfg_data;
  logic                        cfg_err;
  logic                        busy;

  modport master (
    output lookup_req, lookup_addr, cfg_we, cfg_addr, cfg_data,
    input  lookup_ack, lookup_data, cfg_err, busy
  );

  modport slave (
    input  lookup_req, lookup_addr, cfg_we, cfg_addr, cfg_data,
    output lookup_ack, lookup_data, cfg_err, busy
  );
endinterface

// File: rtl/route_table_responder.sv
// Registered, run-time programmable routing table answering router lookups.
// After reset the table walks every entry once, loading the default map, before
// it accepts lookups or configuration writes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// INIT  | walking init_idx over every entry, writing the default map; busy
// READY | serving lookups (one per two cycles) and accepting cfg writes
module route_table_responder #(
  parameter int SIZE         = 8,
  parameter int CHANNELS     = 5,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  route_table_responder_if.slave bus
);

  localparam int DESTINATION_BITS = SIZE - 1;
  localparam int DESTINATIONS     = 2 ** DESTINATION_BITS;

  localparam logic [CHANNEL_BITS-1:0]     CHAN_LIMIT = CHANNEL_BITS'(CHANNELS);
  localparam logic [DESTINATION_BITS-1:0] LAST_IDX   = DESTINATION_BITS'(DESTINATIONS - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                      state_q, state_d;
  logic [DESTINATION_BITS-1:0] init_idx_q, init_idx_d;
  logic [CHANNEL_BITS-1:0]     entry_q [DESTINATIONS];

  logic                        ack_q, ack_d;
  logic [CHANNEL_BITS-1:0]     data_q, data_d;
  logic                        err_q, err_d;
  logic                        accept;
  logic                        cfg_ok;

  // Default map: 0->0, 1->2, 2->1, 3->2, everything else to the last channel.
  function automatic logic [CHANNEL_BITS-1:0] default_entry(
    input logic [DESTINATION_BITS-1:0] idx
  );
    logic [CHANNEL_BITS-1:0] val;
    val = CHANNEL_BITS'(CHANNELS - 1);
    if (idx == DESTINATION_BITS'(0))      val = CHANNEL_BITS'(0);
    else if (idx == DESTINATION_BITS'(1)) val = CHANNEL_BITS'(2);
    else if (idx == DESTINATION_BITS'(2)) val = CHANNEL_BITS'(1);
    else if (idx == DESTINATION_BITS'(3)) val = CHANNEL_BITS'(2);
    return val;
  endfunction

  // State, init walk index and registered responses; reset drops ack at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // Next state, lookup acceptance and config-write qualification.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    accept     = 1'b0;
    cfg_ok     = 1'b0;
    ack_d      = 1'b0;
    data_d     = data_q;
    err_d      = 1'b0;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + DESTINATION_BITS'(1);
        if (init_idx_q == LAST_IDX) state_d = READY;
        // Writes are refused while the default map is still loading.
        err_d = bus.cfg_we;
      end
      READY: begin
        // ack_q blocks back-to-back accepts, giving one lookup per two cycles.
        accept = bus.lookup_req && !ack_q;
        ack_d  = accept;
        if (accept) data_d = entry_q[bus.lookup_addr];
        cfg_ok = bus.cfg_we && (bus.cfg_data < CHAN_LIMIT);
        err_d  = bus.cfg_we && !cfg_ok;
      end
      default: state_d = INIT;
    endcase
  end

  // Table storage; the lookup read above sees the pre-write value on a shared edge.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      entry_q[init_idx_q] <= default_entry(init_idx_q);
    end else if (cfg_ok) begin
      entry_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.lookup_ack  = ack_q;
  assign bus.lookup_data = data_q;
  assign bus.cfg_err     = err_q;
  assign bus.busy        = (state_q == INIT);

endmodule

// File: tb/tb_route_table_responder.sv
// Self-checking bench for route_table_responder: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// table-level model.
module tb_route_table_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  route_table_responder_if #(.DESTINATION_BITS(7), .CHANNEL_BITS(8)) bus ();

  route_table_responder #(.SIZE(8), .CHANNELS(5), .CHANNEL_BITS(8)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the routing table as a plain array plus a countdown of
  // remaining busy cycles.
  logic [7:0] tbl [128];
  int         m_left;
  logic       exp_ack, exp_err, exp_busy;
  logic [7:0] exp_data;
  bit         m_ready, m_acc, m_ok;

  function automatic logic [7:0] dflt(input int a);
    case (a)
      0:       return 8'd0;
      1:       return 8'd2;
      2:       return 8'd1;
      3:       return 8'd2;
      default: return 8'd4;
    endcase
  endfunction

  // Model update on every rising edge; reset refills the defaults at once since
  // nothing can observe the table before the busy window ends.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 128;
      exp_ack  = 1'b0;
      exp_data = 8'd0;
      exp_err  = 1'b0;
      for (int i = 0; i < 128; i++) tbl[i] = dflt(i);
    end else begin
      m_ready = (m_left == 0);
      m_acc   = m_ready && bus.lookup_req && !exp_ack;
      m_ok    = m_ready && bus.cfg_we && (bus.cfg_data < 8'd5);
      exp_err = bus.cfg_we && !m_ok;
      if (m_acc) exp_data = tbl[bus.lookup_addr];
      exp_ack = m_acc;
      if (m_ok) tbl[bus.cfg_addr] = bus.cfg_data;
      if (!m_ready) m_left--;
    end
    exp_busy = (m_left != 0);
  end

  // Compare process: every falling edge out of reset.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("ack",     32'(bus.lookup_ack),  32'(exp_ack));
      chk("data",    32'(bus.lookup_data), 32'(exp_data));
      chk("cfg_err", 32'(bus.cfg_err),     32'(exp_err));
      chk("busy",    32'(bus.busy),        32'(exp_busy));
      chk("ack_back_to_back", 32'(prev_ack & bus.lookup_ack), 32'd0);
      prev_ack = bus.lookup_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic do_lookup(input logic [6:0] a, input logic [7:0] want, input string name);
    int n;
    @(negedge clk);
    bus.lookup_req  = 1'b1;
    bus.lookup_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.lookup_ack && n < 20);
    chk({name, "_latency"}, 32'(n), 32'd1);
    chk({name, "_data"}, 32'(bus.lookup_data), 32'(want));
    bus.lookup_req = 1'b0;
  endtask

  task automatic do_cfg(input logic [6:0] a, input logic [7:0] d, input logic want_err,
                        input string name);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk(name, 32'(bus.cfg_err), 32'(want_err));
  endtask

  int cyc, fall, first;

  initial begin
    bus.lookup_req  = 1'b0;
    bus.lookup_addr = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy),        32'd1);
    chk("reset_ack",  32'(bus.lookup_ack),  32'd0);
    chk("reset_data", 32'(bus.lookup_data), 32'd0);
    chk("reset_err",  32'(bus.cfg_err),     32'd0);

    // Request held through the whole init window.
    bus.lookup_req  = 1'b1;
    bus.lookup_addr = 7'd1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc = 0; fall = 0; first = 0;
    while (first == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy && fall == 0) fall = cyc;
      if (bus.lookup_ack) first = cyc;
    end
    chk("init_length",     32'(fall), 32'd128);
    chk("first_ack_cycle", 32'(first), 32'd129);
    chk("first_ack_data",  32'(bus.lookup_data), 32'd2);
    bus.lookup_req = 1'b0;

    do_lookup(7'd0,   8'd0, "lk0");
    do_lookup(7'd2,   8'd1, "lk2");
    do_lookup(7'd3,   8'd2, "lk3");
    do_lookup(7'd77,  8'd4, "lk77");
    do_lookup(7'd127, 8'd4, "lk127");

    do_cfg(7'd77, 8'd3, 1'b0, "cfg77_ok");
    do_lookup(7'd77, 8'd3, "lk77_prog");
    do_cfg(7'd77, 8'd5, 1'b1, "cfg77_bad");
    do_lookup(7'd77, 8'd3, "lk77_kept");

    // Lookup accepted and write to the same entry on one edge.
    @(negedge clk);
    bus.lookup_req  = 1'b1;
    bus.lookup_addr = 7'd3;
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 7'd3;
    bus.cfg_data    = 8'd0;
    @(negedge clk);
    bus.cfg_we     = 1'b0;
    bus.lookup_req = 1'b0;
    chk("same_edge_ack",  32'(bus.lookup_ack),  32'd1);
    chk("same_edge_data", 32'(bus.lookup_data), 32'd2);
    chk("same_edge_err",  32'(bus.cfg_err),     32'd0);
    do_lookup(7'd3, 8'd0, "lk3_new");

    // Reset in the middle of a lookup, then a rejected write during INIT.
    do_cfg(7'd0, 8'd3, 1'b0, "cfg0_ok");
    do_lookup(7'd0, 8'd3, "lk0_prog");
    @(negedge clk);
    bus.lookup_req  = 1'b1;
    bus.lookup_addr = 7'd0;
    @(posedge clk);
    #1 chk("ack_before_reset", 32'(bus.lookup_ack), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("ack_async_drop", 32'(bus.lookup_ack), 32'd0);
    chk("busy_async_rise", 32'(bus.busy), 32'd1);
    bus.lookup_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.cfg_addr = 7'd5;
    bus.cfg_data = 8'd1;
    cyc = 0; fall = 0;
    while (fall == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) chk("cfg_err_in_init", 32'(bus.cfg_err), 32'd1);
      bus.cfg_we = (cyc == 9);
      if (!bus.busy && fall == 0) fall = cyc;
    end
    bus.cfg_we = 1'b0;
    chk("init_length_after_reset", 32'(fall), 32'd128);
    do_lookup(7'd0,  8'd0, "lk0_restored");
    do_lookup(7'd5,  8'd4, "lk5_default");
    do_lookup(7'd77, 8'd4, "lk77_restored");
    do_lookup(7'd3,  8'd2, "lk3_restored");

    // Randomized traffic; requests stay up until acknowledged.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!(bus.lookup_req && !bus.lookup_ack)) begin
        bus.lookup_req  = 1'($urandom_range(0, 1));
        bus.lookup_addr = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7))
                                                       : 7'($urandom_range(0, 127));
      end
      bus.cfg_we   = ($urandom_range(0, 3) == 0);
      bus.cfg_addr = 7'($urandom_range(0, 7));
      bus.cfg_data = 8'($urandom_range(0, 7));
    end
    @(negedge clk);
    bus.lookup_req = 1'b0;
    bus.cfg_we     = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
